// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART debug-host response path.
package uart_host_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStatus,
        StData,
        StChk
    } resp_state_e;

    localparam logic [3:0]  RespStatusTag = 4'hA;
    localparam int unsigned RespLenRead   = 6;
    localparam int unsigned RespLenShort  = 1;

    function automatic logic [7:0] pack_status(input logic [3:0] tag,
                                               input logic       intg_err,
                                               input logic       err,
                                               input logic       we);
        return {tag, 1'b0, intg_err, err, we};
    endfunction

endpackage

// File: rtl/uart_host_resp_tx.sv
// Encodes completed bus responses as UART TX byte frames:
// status [, d0..d3 LSB first, XOR checksum].
module uart_host_resp_tx
    import uart_host_pkg::*;
#(
    parameter logic [3:0] StatusTag = RespStatusTag
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rsp_valid_i,
    input  logic        rsp_we_i,
    input  logic [31:0] rsp_rdata_i,
    input  logic        rsp_err_i,
    input  logic        rsp_intg_err_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        overrun_o,
    input  logic        clr_overrun_i
);

    resp_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] rdata_q, rdata_d;
    logic        full_q, full_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        overrun_q, overrun_d;

    logic        hs;
    logic [1:0]  idx_inc;
    logic [7:0]  cur_byte;
    logic [7:0]  nxt_byte;
    logic [7:0]  status_byte;

    assign hs          = tx_valid_q & tx_ready_i;
    assign idx_inc     = idx_q + 2'd1;
    assign cur_byte    = rdata_q[{idx_q, 3'b000} +: 8];
    assign nxt_byte    = rdata_q[{idx_inc, 3'b000} +: 8];
    assign status_byte = pack_status(StatusTag, rsp_intg_err_i, rsp_err_i, rsp_we_i);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        rdata_d    = rdata_q;
        full_d     = full_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            StIdle: begin
                if (rsp_valid_i) begin
                    state_d    = StStatus;
                    rdata_d    = rsp_rdata_i;
                    full_d     = ~rsp_we_i & ~rsp_err_i & ~rsp_intg_err_i;
                    chk_d      = status_byte;
                    tx_valid_d = 1'b1;
                    tx_data_d  = status_byte;
                end
            end
            StStatus: begin
                if (hs) begin
                    if (full_q) begin
                        state_d   = StData;
                        idx_d     = 2'd0;
                        tx_data_d = rdata_q[7:0];
                    end else begin
                        state_d    = StIdle;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            StData: begin
                if (hs) begin
                    chk_d = chk_q ^ cur_byte;
                    if (idx_q == 2'd3) begin
                        state_d   = StChk;
                        tx_data_d = chk_q ^ cur_byte;
                    end else begin
                        idx_d     = idx_inc;
                        tx_data_d = nxt_byte;
                    end
                end
            end
            StChk: begin
                if (hs) begin
                    state_d    = StIdle;
                    tx_valid_d = 1'b0;
                end
            end
        endcase

        // A set in the same cycle as a clear must win.
        if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
        if (rsp_valid_i && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            chk_q      <= 8'h00;
            rdata_q    <= 32'h0;
            full_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            rdata_q    <= rdata_d;
            full_q     <= full_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign busy_o     = (state_q != StIdle);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_host_resp_tx.sv
// Bench for uart_host_resp_tx: byte-queue frame model plus directed scenarios.
module tb_uart_host_resp_tx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rsp_valid_i;
    logic        rsp_we_i;
    logic [31:0] rsp_rdata_i;
    logic        rsp_err_i;
    logic        rsp_intg_err_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        overrun_o;
    logic        clr_overrun_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    logic       m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_host_resp_tx dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_we_i       (rsp_we_i),
        .rsp_rdata_i    (rsp_rdata_i),
        .rsp_err_i      (rsp_err_i),
        .rsp_intg_err_i (rsp_intg_err_i),
        .tx_valid_o     (tx_valid_o),
        .tx_data_o      (tx_data_o),
        .tx_ready_i     (tx_ready_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .clr_overrun_i  (clr_overrun_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame derived directly from the byte-format rules.
    task automatic push_frame(input logic we, input logic [31:0] d, input logic err,
                              input logic intg);
        logic [7:0] st;
        logic [7:0] x;
        st = 8'hA0 | {5'b0, intg, err, we};
        exp_q.push_back(st);
        if (!we && !err && !intg) begin
            x = st;
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
                x = x ^ 8'((d >> (8 * i)) & 32'hFF);
            end
            exp_q.push_back(x);
        end
    endtask

    // Compare DUT against model at negedge, then advance the model with the inputs
    // that the next posedge will sample.
    initial begin
        logic idle;
        @(posedge clk);
        forever begin
            @(negedge clk);
            idle = (exp_q.size() == 0);
            chk("busy", {31'b0, busy_o}, {31'b0, !idle});
            chk("tx_valid", {31'b0, tx_valid_o}, {31'b0, !idle});
            if (!idle) chk("tx_data", {24'b0, tx_data_o}, {24'b0, exp_q[0]});
            chk("overrun", {31'b0, overrun_o}, {31'b0, m_ovr});
            if (tx_valid_o && tx_ready_i) seen_q.push_back(tx_data_o);
            if (rst_i) begin
                exp_q.delete();
                m_ovr = 1'b0;
            end else begin
                if (!idle && tx_ready_i) void'(exp_q.pop_front());
                if (rsp_valid_i && idle) push_frame(rsp_we_i, rsp_rdata_i, rsp_err_i,
                                                    rsp_intg_err_i);
                if (rsp_valid_i && !idle) m_ovr = 1'b1;
                else if (clr_overrun_i) m_ovr = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [31:0] d, input logic err,
                        input logic intg);
        rsp_valid_i    = 1'b1;
        rsp_we_i       = we;
        rsp_rdata_i    = d;
        rsp_err_i      = err;
        rsp_intg_err_i = intg;
        step();
        rsp_valid_i    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, {31'b0, busy_o}, 32'd0);
    endtask

    task automatic check_seen(input string name, input logic [7:0] exp[$]);
        chk({name, "_len"}, seen_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < seen_q.size(); i++) begin
            chk($sformatf("%s_b%0d", name, i), {24'b0, seen_q[i]}, {24'b0, exp[i]});
        end
        seen_q.delete();
    endtask

    logic [7:0] rd_frame[$] = '{8'hA0, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h82};

    initial begin
        logic [7:0] one[$];
        int low_run;
        rst_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_we_i = 1'b0;
        rsp_rdata_i = 32'h0;
        rsp_err_i = 1'b0;
        rsp_intg_err_i = 1'b0;
        tx_ready_i = 1'b1;
        clr_overrun_i = 1'b0;
        repeat (3) step();
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data_o}, 32'h00);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_overrun", {31'b0, overrun_o}, 32'd0);
        rst_i = 1'b0;
        step();
        seen_q.delete();

        // Read OK with latency pinned cycle by cycle.
        send(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("rd_n1_valid", {31'b0, tx_valid_o}, 32'd1);
        chk("rd_n1_data", {24'b0, tx_data_o}, 32'hA0);
        chk("rd_n1_busy", {31'b0, busy_o}, 32'd1);
        repeat (5) step();
        chk("rd_n6_data", {24'b0, tx_data_o}, 32'h82);
        chk("rd_n6_busy", {31'b0, busy_o}, 32'd1);
        step();
        chk("rd_n7_busy", {31'b0, busy_o}, 32'd0);
        check_seen("rd_ok", rd_frame);

        // Status-only frames.
        send(1'b1, 32'h12345678, 1'b0, 1'b0);
        step();
        chk("wr_n2_busy", {31'b0, busy_o}, 32'd0);
        one = '{8'hA1};
        check_seen("wr_ok", one);
        send(1'b0, 32'h0, 1'b1, 1'b0);
        wait_idle("rd_err");
        one = '{8'hA2};
        check_seen("rd_err", one);
        send(1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_idle("rd_intg");
        one = '{8'hA4};
        check_seen("rd_intg", one);
        send(1'b1, 32'h0, 1'b1, 1'b1);
        wait_idle("wr_both");
        one = '{8'hA7};
        check_seen("wr_both", one);
        step();

        // Backpressure: ready low for at most 5 cycles in a row.
        send(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        low_run = 0;
        for (int n = 0; n < 300 && busy_o; n++) begin
            if (low_run >= 5 || $urandom_range(0, 2) == 0) begin
                tx_ready_i = 1'b1;
                low_run = 0;
            end else begin
                tx_ready_i = 1'b0;
                low_run++;
            end
            step();
        end
        tx_ready_i = 1'b1;
        wait_idle("bp");
        check_seen("bp", rd_frame);

        // Overrun during DATA index 1.
        send(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        step();
        send(1'b1, 32'h0, 1'b0, 1'b0);
        wait_idle("ovr");
        check_seen("ovr_frame", rd_frame);
        chk("ovr_set", {31'b0, overrun_o}, 32'd1);
        clr_overrun_i = 1'b1;
        step();
        clr_overrun_i = 1'b0;
        chk("ovr_clr", {31'b0, overrun_o}, 32'd0);
        send(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        clr_overrun_i = 1'b1;
        send(1'b1, 32'h0, 1'b0, 1'b0);
        clr_overrun_i = 1'b0;
        chk("ovr_set_wins", {31'b0, overrun_o}, 32'd1);
        wait_idle("ovr2");
        check_seen("ovr2_frame", rd_frame);
        clr_overrun_i = 1'b1;
        step();
        clr_overrun_i = 1'b0;

        // Reset after the second data byte.
        send(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        step();
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
        chk("mid_rst_data", {24'b0, tx_data_o}, 32'h00);
        seen_q.delete();
        send(1'b1, 32'h0, 1'b0, 1'b0);
        wait_idle("post_rst");
        one = '{8'hA1};
        check_seen("post_rst", one);

        // Back-to-back on the first idle cycle.
        send(1'b1, 32'h0, 1'b0, 1'b0);
        step();
        chk("b2b_idle", {31'b0, busy_o}, 32'd0);
        send(1'b0, 32'h0, 1'b1, 1'b0);
        chk("b2b_data", {24'b0, tx_data_o}, 32'hA2);
        chk("b2b_ovr", {31'b0, overrun_o}, 32'd0);
        wait_idle("b2b");
        one = '{8'hA1, 8'hA2};
        check_seen("b2b", one);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
